config_bank: RTL and testbench

CONFIG_BANK -- requirements
Module: config_bank

---
 rtl/config_bank.sv | 137 +++++++++++++
 tb/tb_config_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/config_bank.sv
// rtl/config_bank.sv - double-buffered nibble configuration bank with frame-aligned commit
module config_bank #(
  parameter int                      NUM_FIELDS      = 8,
  parameter logic [NUM_FIELDS*4-1:0] DEFAULT_CFG     = 32'hBBFC_0000,
  parameter bit                      COMMIT_ON_FRAME = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  input  logic                    frame_start,
  output logic [NUM_FIELDS*4-1:0] config_out,
  output logic                    commit_pending,
  output logic [3:0]              rd_data,
  output logic                    rd_valid,
  output logic                    err
);

  localparam int W = NUM_FIELDS * 4;

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;
  logic [7:0]   page_q, page_d;
  logic         pending_q, pending_d;
  logic [3:0]   rd_data_q, rd_data_d;
  logic         rd_valid_q, rd_valid_d;
  logic         err_q, err_d;

  logic         is_write, is_page, is_commit, is_read, is_default;
  logic [10:0]  fidx;
  logic         in_range;
  logic [3:0]   rd_nib;

  // Command decode; nothing is accepted unless data_valid is high.
  assign is_write   = data_valid && !data_in[7];
  assign is_page    = data_valid && (data_in[7:5] == 3'b100);
  assign is_commit  = data_valid && (data_in[7:5] == 3'b101);
  assign is_read    = data_valid && (data_in[7:5] == 3'b110);
  assign is_default = data_valid && (data_in[7:5] == 3'b111);

  // WRITE carries its sub-address in [6:4], READ in [2:0]; the page is the upper part.
  assign fidx     = {page_q, (is_write ? data_in[6:4] : data_in[2:0])};
  assign in_range = (fidx < 11'(NUM_FIELDS));

  // Readback mux selecting shadow or active by data_in[3].
  always_comb begin
    rd_nib = 4'h0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (fidx == 11'(i)) begin
        rd_nib = data_in[3] ? active_q[4*i +: 4] : shadow_q[4*i +: 4];
      end
    end
  end

  // Next-state logic for all registers.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    page_d     = page_q;
    pending_d  = pending_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;

    // Frame-aligned copy uses the pre-edge shadow, so a same-cycle WRITE lands in shadow only.
    if (pending_q && frame_start) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (is_write) begin
      if (in_range) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (fidx == 11'(i)) begin
            shadow_d[4*i +: 4] = data_in[3:0];
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (is_page) begin
      page_d = {3'b000, data_in[4:0]};
    end

    // A COMMIT seen together with frame_start only arms; the copy waits for a later frame.
    if (is_commit) begin
      if (COMMIT_ON_FRAME) begin
        pending_d = 1'b1;
      end else begin
        active_d = shadow_q;
      end
    end

    if (is_read) begin
      if (in_range) begin
        rd_data_d  = rd_nib;
        rd_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (is_default) begin
      shadow_d = DEFAULT_CFG;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= DEFAULT_CFG;
      active_q   <= DEFAULT_CFG;
      page_q     <= 8'h00;
      pending_q  <= 1'b0;
      rd_data_q  <= 4'h0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      page_q     <= page_d;
      pending_q  <= pending_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign config_out     = active_q;
  assign commit_pending = pending_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign err            = err_q;

endmodule

// File: tb/tb_config_bank.sv
// tb/tb_config_bank.sv - directed self-checking bench for config_bank
module tb_config_bank;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        frame_start;
  logic [31:0] config_out;
  logic        commit_pending;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic        err;

  logic [7:0]  d1_data_in;
  logic        d1_data_valid;
  logic        d1_frame_start;
  logic [63:0] d1_config_out;
  logic        d1_commit_pending;
  logic [3:0]  d1_rd_data;
  logic        d1_rd_valid;
  logic        d1_err;

  int checks = 0;
  int errors = 0;

  config_bank dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .frame_start    (frame_start),
    .config_out     (config_out),
    .commit_pending (commit_pending),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .err            (err)
  );

  config_bank #(
    .NUM_FIELDS      (16),
    .DEFAULT_CFG     (64'h0123_4567_89AB_CDEF),
    .COMMIT_ON_FRAME (1'b0)
  ) dut16 (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (d1_data_in),
    .data_valid     (d1_data_valid),
    .frame_start    (d1_frame_start),
    .config_out     (d1_config_out),
    .commit_pending (d1_commit_pending),
    .rd_data        (d1_rd_data),
    .rd_valid       (d1_rd_valid),
    .err            (d1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data_in = 8'h00; data_valid = 1'b0; frame_start = 1'b0;
    d1_data_in = 8'h00; d1_data_valid = 1'b0; d1_frame_start = 1'b0;
    tick(); tick();
    chk("rst_config", {32'h0, config_out}, 64'hBBFC_0000);
    chk("rst_pending", {63'h0, commit_pending}, 64'h0);
    chk("rst_rd_data", {60'h0, rd_data}, 64'h0);
    chk("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
    chk("rst_err", {63'h0, err}, 64'h0);
    chk("rst_cfg16", d1_config_out, 64'h0123_4567_89AB_CDEF);
    rst_n = 1'b1;
    tick();

    // WRITE field3=5, COMMIT, then frame_start
    send(8'h35);
    send(8'hA0);
    chk("commit_armed", {63'h0, commit_pending}, 64'h1);
    chk("cfg_before_frame", {32'h0, config_out}, 64'hBBFC_0000);
    tick();
    chk("cfg_still_before_frame", {32'h0, config_out}, 64'hBBFC_0000);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("cfg_after_frame", {32'h0, config_out}, 64'hBBFC_5000);
    chk("pending_cleared", {63'h0, commit_pending}, 64'h0);

    // Readback from shadow and active
    send(8'h7F);
    send(8'hC7);
    chk("rd_shadow_valid", {63'h0, rd_valid}, 64'h1);
    chk("rd_shadow_data", {60'h0, rd_data}, 64'hF);
    send(8'hCF);
    chk("rd_active_valid", {63'h0, rd_valid}, 64'h1);
    chk("rd_active_data", {60'h0, rd_data}, 64'hB);
    tick();
    chk("rd_valid_drop", {63'h0, rd_valid}, 64'h0);
    chk("rd_data_hold", {60'h0, rd_data}, 64'hB);

    // Out-of-range accesses on page 1 with 8 fields
    send(8'h81);
    chk("page_no_err", {63'h0, err}, 64'h0);
    send(8'h07);
    chk("wr_oob_err", {63'h0, err}, 64'h1);
    tick();
    chk("err_one_cycle", {63'h0, err}, 64'h0);
    send(8'hC8);
    chk("rd_oob_err", {63'h0, err}, 64'h1);
    chk("rd_oob_no_valid", {63'h0, rd_valid}, 64'h0);
    chk("rd_oob_data_hold", {60'h0, rd_data}, 64'hB);
    send(8'h80);
    send(8'hC0);
    chk("oob_shadow_untouched", {60'h0, rd_data}, 64'h0);

    // WRITE in the same cycle as the frame copy
    send(8'hA0);
    chk("pending_again", {63'h0, commit_pending}, 64'h1);
    frame_start = 1'b1; send(8'h01); frame_start = 1'b0;
    chk("frame_copy_preedge", {32'h0, config_out}, 64'hFBFC_5000);
    chk("frame_copy_clear", {63'h0, commit_pending}, 64'h0);
    send(8'hC0);
    chk("shadow_got_write", {60'h0, rd_data}, 64'h1);

    // Repeated COMMIT, then reset mid-operation with a read in flight
    send(8'hA0);
    send(8'hA0);
    chk("repeat_commit", {63'h0, commit_pending}, 64'h1);
    data_in = 8'hC0; data_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cfg", {32'h0, config_out}, 64'hBBFC_0000);
    chk("async_rst_pending", {63'h0, commit_pending}, 64'h0);
    data_valid = 1'b0;
    tick();
    chk("rst_no_rd_valid", {63'h0, rd_valid}, 64'h0);
    chk("rst_rd_data_clr", {60'h0, rd_data}, 64'h0);
    rst_n = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("post_rst_frame_cfg", {32'h0, config_out}, 64'hBBFC_0000);
    chk("post_rst_frame_pend", {63'h0, commit_pending}, 64'h0);

    // COMMIT together with frame_start only arms
    send(8'h0C);
    frame_start = 1'b1; send(8'hA0); frame_start = 1'b0;
    chk("commit_frame_arms", {63'h0, commit_pending}, 64'h1);
    chk("commit_frame_nocopy", {32'h0, config_out}, 64'hBBFC_0000);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("later_frame_copy", {32'h0, config_out}, 64'hBBFC_000C);

    // Idle frame, ignored data, DEFAULT command
    send(8'h03);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("idle_frame_noop", {32'h0, config_out}, 64'hBBFC_000C);
    data_in = 8'h0F; data_valid = 1'b0; tick();
    send(8'hC0);
    chk("invalid_ignored", {60'h0, rd_data}, 64'h3);
    send(8'hE0);
    send(8'hC0);
    chk("default_shadow", {60'h0, rd_data}, 64'h0);
    chk("default_keeps_active", {32'h0, config_out}, 64'hBBFC_000C);

    // 16-field instance with immediate commit
    d1_data_in = 8'h81; d1_data_valid = 1'b1; tick();
    d1_data_in = 8'h2A; tick();
    d1_data_valid = 1'b0;
    chk("imm_before_commit", d1_config_out, 64'h0123_4567_89AB_CDEF);
    d1_data_in = 8'hA0; d1_data_valid = 1'b1; tick();
    d1_data_valid = 1'b0;
    chk("imm_commit_cfg", d1_config_out, 64'h0123_4A67_89AB_CDEF);
    chk("imm_no_pending", {63'h0, d1_commit_pending}, 64'h0);
    chk("imm_no_err", {63'h0, d1_err}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
